// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_port_arbiter #(
    parameter int size         = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_wb_valid,
    input  logic              pipe_reg_wr,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [size-1:0]   pipe_wdata,
    output logic              pipe_stall,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [size-1:0]   lu_wdata,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [size-1:0]   rf_wdata,
    output logic              lu_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [size-1:0]   data_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [size-1:0]   rf_wdata_q, rf_wdata_d;

    logic empty, full, push, pop, pipe_req, grant_pipe;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign lu_ready   = !full;
    assign lu_busy    = !empty;
    assign push       = lu_valid && lu_ready;
    assign pipe_req   = pipe_wb_valid && pipe_reg_wr && (pipe_rd != '0);
    assign grant_pipe = pipe_req && !pipe_stall;
    assign pop        = !grant_pipe && !empty;

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    // Count cycles the head waits; saturate so the guard stays asserted.
    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    assign pipe_stall = pipe_req && (starve_q >= SW'(STARVE_LIMIT));

    // Starvation counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve;
    assign unused_starve = (STARVE_LIMIT == 0);
    assign pipe_stall    = 1'b0;
`endif

    // FIFO pointer and occupancy update; wrap is natural for power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Select the winning write; x0 FIFO entries retire silently.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_pipe) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_rd;
            rf_wdata_d = pipe_wdata;
        end else if (pop && (rd_q[rd_ptr_q] != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
        end
    end

    // FIFO control and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // FIFO storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= lu_rd;
            data_q[wr_ptr_q] <= lu_wdata;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between two sources.
- Source 1: the in-order pipeline writeback, i.e. the already-muxed result of the writeback-select mux (DMem / ALU / PC+4).
- Source 2: a long-latency execution unit (multi-cycle mul/div) that returns results out of band.
- Buffers long-latency results in a small FIFO, registers the winning write onto the register file, and can stall the pipeline so long-latency results are not starved.

Parameters:
- size, 32, data width of all write data.
- ADDR_W, 5, register index width.
- DEPTH, 4, long-latency result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 8, cycles a FIFO head may wait before a forced grant (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_wb_valid  in  1  pipeline writeback slot holds an instruction this cycle.
- pipe_reg_wr  in  1  that instruction writes a register.
- pipe_rd  in  ADDR_W  destination register of the pipeline write.
- pipe_wdata  in  size  output of the writeback-select mux.
- pipe_stall  out  1  pipeline must hold its writeback slot this cycle.
- lu_valid  in  1  long-latency unit offers a result.
- lu_rd  in  ADDR_W  destination of the offered result.
- lu_wdata  in  size  offered result data.
- lu_ready  out  1  FIFO accepts the offered result this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_W  register-file write address (registered).
- rf_wdata  out  size  register-file write data (registered).
- lu_busy  out  1  FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty: pointers and count = 0. Starvation counter = 0.
  - lu_ready=1 and lu_busy=0 once FIFO empty; pipe_stall=0.
  - Reset mid-operation discards all FIFO contents; no write is issued.
- FIFO:
  - Push on lu_valid && lu_ready.
  - lu_ready = !full. No same-cycle pop credit: when full, lu_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH; count is ADDR-independent, width clog2(DEPTH)+1.
  - Push and pop in the same cycle: count unchanged.
- Pipeline request is active when pipe_wb_valid && pipe_reg_wr && pipe_rd != 0.
- Arbitration, evaluated combinationally each cycle:
  - Grant pipeline if its request is active and pipe_stall=0.
  - Otherwise grant the FIFO head if non-empty (pop).
  - Otherwise no write.
- Base priority: pipeline strictly over FIFO. pipe_stall is constant 0 without the optional feature.
- FIFO entries with rd=0 are popped without asserting rf_we.
- Write port latency:
  - The granted write appears on rf_we/rf_waddr/rf_wdata at the next rising edge.
  - It is held for exactly one cycle; rf_we=0 otherwise.
  - rf_waddr and rf_wdata retain their last values when rf_we=0.
- Ordering:
  - FIFO results retire in arrival order.
  - No rd hazard checking; the issue logic guarantees the pipeline never targets an rd pending in the long-latency unit.
- A pipeline instruction with pipe_reg_wr=0 (store, branch) never blocks a FIFO pop.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle the FIFO is non-empty and the head is not popped.
  - The counter clears on pop or when the FIFO is empty.
  - When counter ≥ STARVE_LIMIT and the pipeline request is active, pipe_stall=1 (combinational) that cycle.
  - While pipe_stall=1, the FIFO head is granted and the pipeline slot is ignored; the pipeline re-presents it next cycle.
  - The counter saturates and never wraps.
- Undefined:
  - No counter logic; pipe_stall tied 0.
  - Pipeline has absolute priority; FIFO entries can wait indefinitely.

Test Plan:
- Pipeline only: pipe_wb_valid=1, pipe_reg_wr=1, rd=5, wdata=0x0000_00AA → next cycle rf_we=1, waddr=5, wdata=0xAA; then rf_we=0.
- x0 suppression: pipe rd=0, data 0x1234 → rf_we stays 0. FIFO entry with rd=0 → popped, lu_busy drops, no write.
- Idle-slot drain: push lu rd=7, data 0xDEAD_BEEF while pipeline idle → write (7, 0xDEADBEEF) on the cycle after the push is visible at the head; lu_busy returns to 0.
- FIFO full/back-pressure (DEPTH=4): continuous pipeline writes while pushing 5 results → lu_ready=0 after 4 accepted. The 5th is held by the unit. All 4 retire in order once the pipeline idles, and lu_ready rises again.
- Starvation guard (macro defined, STARVE_LIMIT=8): one FIFO entry plus continuous pipeline writes → pipe_stall=1 in exactly the 9th waiting cycle, the FIFO write issues next cycle, and the stalled pipeline write follows one cycle later. With the macro undefined → pipe_stall never asserts.
- Async reset mid-operation: FIFO holding 3 entries, rst_n pulsed low between edges → rf_we=0, lu_busy=0, lu_ready=1 immediately; no stale writes after release.
